// File: rtl/core_decode.sv
// rtl/core_decode.sv - registered RV32I instruction field and flag decoder
//
// Purpose: splits an RV32I instruction word into register numbers, the
// extended immediate and one-hot instruction flags, all registered with a
// single cycle of latency. A new instruction is accepted every cycle.
//
// Ports:
//   rst      in   1   asynchronous active-high reset, clears every output
//   clk      in   1   clock, rising edge
//   inst     in   32  instruction word
//   rd_num   out  5   inst[11:7]
//   rs1_num  out  5   inst[19:15]
//   rs2_num  out  5   inst[24:20]
//   imm      out  32  immediate selected by opcode format, 0 for R-type/other
//   i_*      out  1   one flag per decoded instruction, at most one high
//   n_inst   out  1   high when no flag is set (after reset has released)

module core_decode (
    input  logic        rst,
    input  logic        clk,
    input  logic [31:0] inst,
    output logic [4:0]  rd_num,
    output logic [4:0]  rs1_num,
    output logic [4:0]  rs2_num,
    output logic [31:0] imm,
    output logic        i_addi,
    output logic        i_slti,
    output logic        i_sltiu,
    output logic        i_xori,
    output logic        i_ori,
    output logic        i_andi,
    output logic        i_slli,
    output logic        i_srli,
    output logic        i_srai,
    output logic        i_add,
    output logic        i_sub,
    output logic        i_sll,
    output logic        i_slt,
    output logic        i_sltu,
    output logic        i_xor,
    output logic        i_srl,
    output logic        i_sra,
    output logic        i_or,
    output logic        i_and,
    output logic        i_beq,
    output logic        i_bne,
    output logic        i_blt,
    output logic        i_bge,
    output logic        i_bltu,
    output logic        i_bgeu,
    output logic        i_lb,
    output logic        i_lh,
    output logic        i_lw,
    output logic        i_lbu,
    output logic        i_lhu,
    output logic        i_sb,
    output logic        i_sh,
    output logic        i_sw,
    output logic        n_inst
);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Bit positions in the flag vector, in port order.
    localparam int F_ADDI = 0,  F_SLTI = 1,  F_SLTIU = 2, F_XORI = 3;
    localparam int F_ORI  = 4,  F_ANDI = 5,  F_SLLI  = 6, F_SRLI = 7;
    localparam int F_SRAI = 8,  F_ADD  = 9,  F_SUB   = 10, F_SLL = 11;
    localparam int F_SLT  = 12, F_SLTU = 13, F_XOR   = 14, F_SRL = 15;
    localparam int F_SRA  = 16, F_OR   = 17, F_AND   = 18, F_BEQ = 19;
    localparam int F_BNE  = 20, F_BLT  = 21, F_BGE   = 22, F_BLTU = 23;
    localparam int F_BGEU = 24, F_LB   = 25, F_LH    = 26, F_LW  = 27;
    localparam int F_LBU  = 28, F_LHU  = 29, F_SB    = 30, F_SH  = 31;
    localparam int F_SW   = 32;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        alt;
    logic [31:0] imm_d;
    logic [32:0] flag_d;
    logic [32:0] flag_q;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    // inst[30] is the only funct7 bit that matters in RV32I base.
    assign alt    = inst[30];

    always_comb begin
        imm_d = 32'd0;
        case (opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm_d = {{20{inst[31]}}, inst[31:20]};
            OPC_STORE:
                imm_d = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            OPC_BRANCH:
                imm_d = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_d = {inst[31:12], 12'd0};
            OPC_JAL:
                imm_d = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:
                imm_d = 32'd0;
        endcase
    end

    always_comb begin
        flag_d = '0;
        case (opcode)
            OPC_OP_IMM: begin
                case (funct3)
                    3'b000: flag_d[F_ADDI]  = 1'b1;
                    3'b010: flag_d[F_SLTI]  = 1'b1;
                    3'b011: flag_d[F_SLTIU] = 1'b1;
                    3'b100: flag_d[F_XORI]  = 1'b1;
                    3'b110: flag_d[F_ORI]   = 1'b1;
                    3'b111: flag_d[F_ANDI]  = 1'b1;
                    3'b001: flag_d[F_SLLI]  = 1'b1;
                    default: begin
                        if (alt) flag_d[F_SRAI] = 1'b1;
                        else     flag_d[F_SRLI] = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                case (funct3)
                    3'b000: begin
                        if (alt) flag_d[F_SUB] = 1'b1;
                        else     flag_d[F_ADD] = 1'b1;
                    end
                    3'b001: flag_d[F_SLL]  = 1'b1;
                    3'b010: flag_d[F_SLT]  = 1'b1;
                    3'b011: flag_d[F_SLTU] = 1'b1;
                    3'b100: flag_d[F_XOR]  = 1'b1;
                    3'b101: begin
                        if (alt) flag_d[F_SRA] = 1'b1;
                        else     flag_d[F_SRL] = 1'b1;
                    end
                    3'b110: flag_d[F_OR]   = 1'b1;
                    default: flag_d[F_AND] = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                case (funct3)
                    3'b000: flag_d[F_BEQ]  = 1'b1;
                    3'b001: flag_d[F_BNE]  = 1'b1;
                    3'b100: flag_d[F_BLT]  = 1'b1;
                    3'b101: flag_d[F_BGE]  = 1'b1;
                    3'b110: flag_d[F_BLTU] = 1'b1;
                    3'b111: flag_d[F_BGEU] = 1'b1;
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                case (funct3)
                    3'b000: flag_d[F_LB]  = 1'b1;
                    3'b001: flag_d[F_LH]  = 1'b1;
                    3'b010: flag_d[F_LW]  = 1'b1;
                    3'b100: flag_d[F_LBU] = 1'b1;
                    3'b101: flag_d[F_LHU] = 1'b1;
                    default: ;
                endcase
            end
            OPC_STORE: begin
                case (funct3)
                    3'b000: flag_d[F_SB] = 1'b1;
                    3'b001: flag_d[F_SH] = 1'b1;
                    3'b010: flag_d[F_SW] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // n_inst is registered separately so it reads 0 during reset rather
    // than being derived from the cleared flag vector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_num  <= 5'd0;
            rs1_num <= 5'd0;
            rs2_num <= 5'd0;
            imm     <= 32'd0;
            flag_q  <= '0;
            n_inst  <= 1'b0;
        end else begin
            rd_num  <= inst[11:7];
            rs1_num <= inst[19:15];
            rs2_num <= inst[24:20];
            imm     <= imm_d;
            flag_q  <= flag_d;
            n_inst  <= ~|flag_d;
        end
    end

    assign {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb,
            i_bgeu, i_bltu, i_bge, i_blt, i_bne, i_beq,
            i_and, i_or, i_sra, i_srl, i_xor, i_sltu, i_slt, i_sll, i_sub, i_add,
            i_srai, i_srli, i_slli, i_andi, i_ori, i_xori, i_sltiu, i_slti, i_addi} = flag_q;

endmodule

// File: tb/tb_core_decode.sv
// tb/tb_core_decode.sv - directed vector testbench for core_decode

module tb_core_decode;

    logic        rst;
    logic        clk;
    logic [31:0] inst;
    logic [4:0]  rd_num, rs1_num, rs2_num;
    logic [31:0] imm;
    logic i_addi, i_slti, i_sltiu, i_xori, i_ori, i_andi, i_slli, i_srli, i_srai;
    logic i_add, i_sub, i_sll, i_slt, i_sltu, i_xor, i_srl, i_sra, i_or, i_and;
    logic i_beq, i_bne, i_blt, i_bge, i_bltu, i_bgeu;
    logic i_lb, i_lh, i_lw, i_lbu, i_lhu, i_sb, i_sh, i_sw;
    logic n_inst;
    logic [32:0] flags;

    int tests_run = 0;
    int tests_failed = 0;

    core_decode dut (
        .rst(rst), .clk(clk), .inst(inst),
        .rd_num(rd_num), .rs1_num(rs1_num), .rs2_num(rs2_num), .imm(imm),
        .i_addi(i_addi), .i_slti(i_slti), .i_sltiu(i_sltiu), .i_xori(i_xori),
        .i_ori(i_ori), .i_andi(i_andi), .i_slli(i_slli), .i_srli(i_srli), .i_srai(i_srai),
        .i_add(i_add), .i_sub(i_sub), .i_sll(i_sll), .i_slt(i_slt), .i_sltu(i_sltu),
        .i_xor(i_xor), .i_srl(i_srl), .i_sra(i_sra), .i_or(i_or), .i_and(i_and),
        .i_beq(i_beq), .i_bne(i_bne), .i_blt(i_blt), .i_bge(i_bge), .i_bltu(i_bltu),
        .i_bgeu(i_bgeu), .i_lb(i_lb), .i_lh(i_lh), .i_lw(i_lw), .i_lbu(i_lbu),
        .i_lhu(i_lhu), .i_sb(i_sb), .i_sh(i_sh), .i_sw(i_sw), .n_inst(n_inst)
    );

    // Bit i of flags is the i-th flag in port order (i_addi = bit 0 ... i_sw = bit 32).
    assign flags = {i_sw, i_sh, i_sb, i_lhu, i_lbu, i_lw, i_lh, i_lb,
                    i_bgeu, i_bltu, i_bge, i_blt, i_bne, i_beq,
                    i_and, i_or, i_sra, i_srl, i_xor, i_sltu, i_slt, i_sll, i_sub, i_add,
                    i_srai, i_srli, i_slli, i_andi, i_ori, i_xori, i_sltiu, i_slti, i_addi};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        int          fidx;   // expected flag bit, -1 for none
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, " rd"},   64'(rd_num),  64'd0);
        check({name, " rs1"},  64'(rs1_num), 64'd0);
        check({name, " rs2"},  64'(rs2_num), 64'd0);
        check({name, " imm"},  64'(imm),     64'd0);
        check({name, " flags"}, 64'(flags),  64'd0);
        check({name, " n_inst"}, 64'(n_inst), 64'd0);
    endtask

    task automatic check_vec(input string name, input vec_t v);
        logic [32:0] ef;
        ef = '0;
        if (v.fidx >= 0) ef[v.fidx] = 1'b1;
        check({name, " rd"},     64'(rd_num),  64'(v.rd));
        check({name, " rs1"},    64'(rs1_num), 64'(v.rs1));
        check({name, " rs2"},    64'(rs2_num), 64'(v.rs2));
        check({name, " imm"},    64'(imm),     64'(v.imm));
        check({name, " flags"},  64'(flags),   64'(ef));
        check({name, " n_inst"}, 64'(n_inst),  64'(v.fidx < 0));
    endtask

    initial begin
        //          inst          rd  rs1 rs2 imm           flag
        vecs[0]  = '{32'hC0138A93, 21, 7,  1,  32'hFFFFFC01, 0};   // addi
        vecs[1]  = '{32'h4013DA93, 21, 7,  1,  32'h00000401, 8};   // srai
        vecs[2]  = '{32'h0013DA93, 21, 7,  1,  32'h00000001, 7};   // srli
        vecs[3]  = '{32'h4013DAB3, 21, 7,  1,  32'h00000000, 16};  // sra
        vecs[4]  = '{32'h0013DAB3, 21, 7,  1,  32'h00000000, 15};  // srl
        vecs[5]  = '{32'h40138AB3, 21, 7,  1,  32'h00000000, 10};  // sub
        vecs[6]  = '{32'h00138AB3, 21, 7,  1,  32'h00000000, 9};   // add
        vecs[7]  = '{32'hFAAAF0B7, 1,  21, 10, 32'hFAAAF000, -1};  // lui
        vecs[8]  = '{32'h7FE991EF, 3,  19, 30, 32'h000997FE, -1};  // jal
        vecs[9]  = '{32'h00602223, 4,  0,  6,  32'h00000004, 32};  // sw
        vecs[10] = '{32'hFE000EE3, 29, 0,  0,  32'hFFFFFFFC, 19};  // beq, negative offset
        vecs[11] = '{32'h0040A103, 2,  1,  4,  32'h00000004, 27};  // lw
        vecs[12] = '{32'hFFFFFFFF, 31, 31, 31, 32'h00000000, -1};  // illegal opcode
        vecs[13] = '{32'h00002063, 0,  0,  0,  32'h00000000, -1};  // branch, undefined funct3
        vecs[14] = '{32'h00109093, 1,  1,  1,  32'h00000001, 6};   // slli
        vecs[15] = '{32'h0020F1B3, 3,  1,  2,  32'h00000000, 18};  // and
        vecs[16] = '{32'hFFC08067, 0,  1,  28, 32'hFFFFFFFC, -1};  // jalr
        vecs[17] = '{32'hFE20B1B3, 3,  1,  2,  32'h00000000, 13};  // sltu, funct7 ignored
        vecs[18] = '{32'hFE111FA3, 31, 2,  1,  32'hFFFFFFFF, 31};  // sh, negative offset
        vecs[19] = '{32'h00001017, 0,  0,  0,  32'h00001000, -1};  // auipc

        // Reset state with a live instruction on the input.
        rst  = 1'b1;
        inst = 32'hC0138A93;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Back-to-back vectors, one per cycle; checked 1 time unit after the edge.
        for (int i = 0; i < 20; i++) begin
            inst = vecs[i].inst;
            @(posedge clk); #1;
            check_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges clears outputs immediately.
        inst = vecs[0].inst;
        @(posedge clk); #1;
        check_vec("pre_rst", vecs[0]);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check_all_zero($sformatf("rst_hold%0d", k));
        end

        // First valid output appears at the first edge after release.
        inst = vecs[1].inst;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst_release_no_edge");
        @(posedge clk); #1;
        check_vec("post_rst", vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
